// File: rtl/rom_stream_reader_pkg.sv
// Shared definitions for the ROM stream reader.
//   state_t        sequencer states
//   DEFAULT_*      default ROM geometry (256 x 8)
//   MAX_COUNT      words in a full ROM sweep at the default geometry
package rom_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEFAULT_ADDR_W = 8;
  localparam int DEFAULT_DATA_W = 8;
  localparam int MAX_COUNT      = 2 ** DEFAULT_ADDR_W;

endpackage

// File: rtl/rom_stream_fifo.sv
// Small synchronous FIFO holding {last, data} words on their way to the stream port.
//   clk, rst_n   clock, synchronous active-low reset (clears occupancy only)
//   push, wdata  write strobe and word
//   pop, rdata   read strobe and head word (rdata is the current head)
//   full, empty  occupancy flags
//   count        number of stored words
module rom_stream_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rom_stream_reader.sv
// Reads a run of consecutive words from a 1-cycle-latency synchronous ROM and
// streams them out on a valid/ready port, marking the final word.
//   clk, rst_n           clock, synchronous active-low reset
//   start                transfer request, only honoured while idle
//   base_addr, count     first address and word count (count > 2**ADDR_W clamps)
//   busy, done           transfer in progress / one-cycle completion pulse
//   rom_addr, rom_data   ROM read address and returned word (next cycle)
//   m_data, m_valid,
//   m_ready, m_last      output stream
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing ROM reads as FIFO credit allows
// DRAIN | all reads issued, waiting for the last word to leave
module rom_stream_reader
  import rom_stream_reader_pkg::*;
#(
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] REM_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   remaining;
  logic              inflight;
  logic              inflight_last;
  logic              issue;
  logic              accept;
  logic              done_next;
  logic              credit_ok;
  logic              pop;
  logic              full;
  logic              empty;
  logic [DATA_W:0]   head;
  logic [CNT_W-1:0]  fifo_count;

  // The in-flight read already owns a FIFO slot, so it is counted as occupied.
  assign credit_ok = ~full && ((int'(fifo_count) + int'(inflight)) < FIFO_DEPTH);
  assign pop       = m_valid & m_ready;
  assign rom_addr  = ptr;
  assign busy      = (state != IDLE);
  assign m_valid   = ~empty;
  assign m_data    = head[DATA_W-1:0];
  assign m_last    = head[DATA_W] & m_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    issue      = 1'b0;
    accept     = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (count == '0) begin
            done_next = 1'b1;
          end else begin
            accept     = 1'b1;
            next_state = RUN;
          end
        end
      end
      RUN: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (remaining == REM_ONE) next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && m_last) begin
          next_state = IDLE;
          done_next  = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr           <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done          <= 1'b0;
    end else begin
      done     <= done_next;
      inflight <= issue;
      if (issue) inflight_last <= (remaining == REM_ONE);
      if (accept) begin
        ptr       <= base_addr;
        remaining <= (count > MAX_WORDS) ? MAX_WORDS : count;
      end else if (issue) begin
        ptr       <= ptr + ADDR_W'(1);
        remaining <= remaining - REM_ONE;
      end
    end
  end

  rom_stream_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .wdata ({inflight_last, rom_data}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_rom_stream_reader.sv
module tb_rom_stream_reader;
  import rom_stream_reader_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] base_addr;
  logic [8:0] count;
  logic       busy;
  logic       done;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int busy_cycles;
  int done_cnt;
  bit ready_mode = 1'b0;
  bit overflow_seen = 1'b0;
  bit prev_stall = 1'b0;
  logic [9:0] prev_beat;

  int beat_data[$];
  int beat_last[$];
  int beat_cyc[$];

  always #5 clk = ~clk;

  rom_stream_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last)
  );

  // ROM contents: rom[i] = i ^ 8'hA5, one cycle read latency
  always @(posedge clk) rom_data <= rom_addr ^ 8'hA5;

  always @(posedge clk) begin
    cyc++;
    #1;
    m_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid && m_ready) begin
        beat_data.push_back(int'(m_data));
        beat_last.push_back(int'(m_last));
        beat_cyc.push_back(cyc);
      end
      if (busy) busy_cycles++;
      if (done) done_cnt++;
      if (prev_stall) check("stall_hold", int'({m_valid, m_last, m_data}), int'(prev_beat));
      prev_stall = m_valid && !m_ready;
      prev_beat  = {m_valid, m_last, m_data};
    end else begin
      prev_stall = 1'b0;
    end
    if (int'(dut.fifo_count) > 4) overflow_seen = 1'b1;
  end

  task automatic clear_obs();
    beat_data.delete();
    beat_last.delete();
    beat_cyc.delete();
    busy_cycles = 0;
    done_cnt    = 0;
  endtask

  task automatic do_start(input logic [7:0] b, input logic [8:0] c);
    @(posedge clk); #1;
    base_addr = b;
    count     = c;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, int'(done), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_beats(input string tag, input int b, input int n);
    check({tag, "_nbeats"}, beat_data.size(), n);
    for (int i = 0; i < n && i < beat_data.size(); i++) begin
      check({tag, "_data"}, beat_data[i], ((b + i) % 256) ^ 'hA5);
      check({tag, "_last"}, beat_last[i], int'(i == n - 1));
    end
  endtask

  initial begin
    int guard;
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    count     = '0;
    m_ready   = 1'b1;
    clear_obs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_valid", int'(m_valid), 0);
    check("rst_last", int'(m_last), 0);
    check("rst_addr", int'(rom_addr), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: basic run, full throughput
    clear_obs();
    do_start(8'h10, 9'd8);
    wait_done("t1", 40);
    check_beats("t1", 'h10, 8);
    if (beat_cyc.size() == 8) check("t1_gap", beat_cyc[7] - beat_cyc[0], 7);
    check("t1_busy_cycles", busy_cycles, 10);
    check("t1_done_cnt", done_cnt, 1);

    // 2: address wrap
    clear_obs();
    do_start(8'hFE, 9'd4);
    wait_done("t2", 40);
    check_beats("t2", 'hFE, 4);

    // 3: random backpressure
    clear_obs();
    ready_mode = 1'b1;
    do_start(8'h00, 9'd16);
    wait_done("t3", 400);
    ready_mode = 1'b0;
    check_beats("t3", 'h00, 16);
    check("t3_done_cnt", done_cnt, 1);

    // 4a: zero count
    clear_obs();
    do_start(8'h33, 9'd0);
    @(negedge clk);
    check("t4_done_pulse", int'(done), 1);
    check("t4_busy", int'(busy), 0);
    @(negedge clk);
    check("t4_done_low", int'(done), 0);
    repeat (3) @(negedge clk);
    check("t4_nbeats", beat_data.size(), 0);
    check("t4_busy_cycles", busy_cycles, 0);

    // 4b: oversized count clamps to a full sweep
    clear_obs();
    do_start(8'h40, 9'd300);
    wait_done("t4b", 600);
    check_beats("t4b", 'h40, MAX_COUNT);
    if (beat_data.size() > 0)
      check("t4b_final", beat_data[beat_data.size() - 1], 'h3F ^ 'hA5);

    // 5: start while busy is ignored
    clear_obs();
    do_start(8'h30, 9'd8);
    repeat (3) @(posedge clk);
    #1;
    base_addr = 8'h99;
    count     = 9'd5;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t5", 40);
    check_beats("t5", 'h30, 8);
    check("t5_done_cnt", done_cnt, 1);

    // 6: reset mid-transfer
    clear_obs();
    do_start(8'h50, 9'd10);
    guard = 0;
    while (beat_data.size() < 3 && guard < 50) begin
      @(posedge clk);
      guard++;
    end
    check("t6_three_beats", beat_data.size(), 3);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_valid_after_rst", int'(m_valid), 0);
    check("t6_busy_after_rst", int'(busy), 0);
    repeat (5) @(negedge clk);
    check("t6_no_done", done_cnt, 0);
    check("t6_no_more_beats", beat_data.size(), 3);
    clear_obs();
    do_start(8'h20, 9'd2);
    wait_done("t6b", 40);
    check_beats("t6b", 'h20, 2);

    check("no_overflow", int'(overflow_seen), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
